ofmap_writeback: RTL

Collects post-PPU output elements from the accelerator top (one element per `in_valid` beat, with no backpressure) and turns them into 32-bit DRAM write beats. In int8 mode it packs four bytes per word; in raw mode it passes 32-bit words through. Words are buffered in a small FIFO, drained over a valid/ready write port with byte addresses, and `done` is raised once everything has been flushed. It sits directly downstream of the compute top's `valid`/`ofmap`/`done` outputs.

---
 rtl/ofmap_writeback_if.sv | 14 +
 rtl/ofmap_writeback.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ofmap_writeback_if.sv
// DRAM write port of ofmap_writeback: one 32-bit beat with byte address and
// byte enables, transferred on valid && ready.
interface ofmap_writeback_if #(
  parameter int ADDR_W = 16
);
  logic              valid;
  logic              ready;
  logic [31:0]       data;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        strb;

  modport master (output valid, data, addr, strb, input ready);
  modport slave  (input valid, data, addr, strb, output ready);
endinterface

// File: rtl/ofmap_writeback.sv
// Packs post-PPU elements (int8 x4 or raw 32-bit) into DRAM write beats via a
// small FIFO. Optional stats counters enabled by macro OFMAP_WB_STATS_EN.
module ofmap_writeback #(
  parameter int                FIFO_DEPTH = 8,
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode_raw,
  input  logic               in_valid,
  input  logic [31:0]        in_data,
  input  logic               in_last,
  ofmap_writeback_if.master  wr,
  output logic               busy,
  output logic               done,
  output logic               err
`ifdef OFMAP_WB_STATS_EN
  ,
  output logic [15:0]        stat_beats,
  output logic [15:0]        stat_stalls
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t            state, state_nx;
  logic              raw_q;
  logic [1:0]        pack_cnt;
  logic [23:0]       held;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;

  logic [35:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count, count_nx;

  logic              start_ok;
  logic              push, push_ok, pop, full;
  logic [31:0]       push_data, merged;
  logic [3:0]        push_strb;

  function automatic logic [3:0] low_mask(input logic [2:0] n);
    low_mask = 4'((5'd1 << n) - 5'd1);
  endfunction

  assign start_ok = start && (state == S_IDLE);
  assign full     = (count == (PW+1)'(FIFO_DEPTH));
  assign pop      = (count != '0) && wr.ready;
  assign push_ok  = push && (!full || pop);
  assign count_nx = count + (PW+1)'(push_ok) - (PW+1)'(pop);

  // Incoming byte dropped into the next free lane of the held bytes.
  assign merged = {8'h00, held} | ({24'h0, in_data[7:0]} << {pack_cnt, 3'b000});

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    push_strb = '0;
    if (state == S_RUN) begin
      if (raw_q) begin
        if (in_valid) begin
          push      = 1'b1;
          push_data = in_data;
          push_strb = 4'hF;
        end
      end else if (in_valid) begin
        if (pack_cnt == 2'd3) begin
          push      = 1'b1;
          push_data = merged;
          push_strb = 4'hF;
        end else if (in_last) begin
          push      = 1'b1;
          push_data = merged;
          push_strb = low_mask({1'b0, pack_cnt} + 3'd1);
        end
      end else if (in_last && (pack_cnt != 2'd0)) begin
        push      = 1'b1;
        push_data = {8'h00, held};
        push_strb = low_mask({1'b0, pack_cnt});
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || start_ok || (state == S_RUN && in_last)) begin
      pack_cnt <= 2'd0;
      held     <= '0;
    end else if (state == S_RUN && in_valid && !raw_q) begin
      held     <= (pack_cnt == 2'd3) ? 24'h0 : merged[23:0];
      pack_cnt <= pack_cnt + 2'd1;
    end
  end

  // NOTE: the FIFO storage is not reset; the pointers and count define what is
  // valid, and the head is masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {push_strb, push_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      count <= count_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start_ok) addr_q <= BASE_ADDR;
    else if (pop)        addr_q <= addr_q + ADDR_W'(4);
  end

  always_ff @(posedge clk) begin
    if (rst || start_ok) err_q <= 1'b0;
    else if ((push && !push_ok) || (state == S_FLUSH && in_valid)) err_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)           raw_q <= 1'b0;
    else if (start_ok) raw_q <= mode_raw;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // FLUSH ends on the edge that empties the FIFO, so done follows the last pop.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start)              state_nx = S_RUN;
      S_RUN:   if (in_last)            state_nx = S_FLUSH;
      S_FLUSH: if (count_nx == '0)     state_nx = S_DONE;
      S_DONE:                          state_nx = S_IDLE;
      default:                         state_nx = S_IDLE;
    endcase
  end

  assign wr.valid              = (count != '0);
  assign {wr.strb, wr.data}    = wr.valid ? mem[rd_ptr] : 36'h0;
  assign wr.addr               = addr_q;
  assign busy                  = (state == S_RUN) || (state == S_FLUSH);
  assign done                  = (state == S_DONE);
  assign err                   = err_q;

`ifdef OFMAP_WB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      stat_beats  <= '0;
      stat_stalls <= '0;
    end else begin
      if (pop && stat_beats != 16'hFFFF) stat_beats <= stat_beats + 16'd1;
      if (wr.valid && !wr.ready && stat_stalls != 16'hFFFF)
        stat_stalls <= stat_stalls + 16'd1;
    end
  end
`endif

endmodule
